// File: rtl/seq_divider_pkg.sv
// Shared definitions for the sequential divider: op and state encodings,
// default datapath width and small op-decode helpers.
package seq_divider_pkg;

    localparam int DIV_WIDTH = 32;

    typedef enum logic [1:0] {
        OP_DIV  = 2'b00,
        OP_DIVU = 2'b01,
        OP_REM  = 2'b10,
        OP_REMU = 2'b11
    } div_op_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_FIX  = 2'b10,
        S_DONE = 2'b11
    } div_state_e;

    // DIV and REM treat operands as two's complement; DIVU/REMU do not.
    function automatic logic op_is_signed(input div_op_e op);
        return (op == OP_DIV) || (op == OP_REM);
    endfunction

    // REM/REMU return the remainder, DIV/DIVU the quotient.
    function automatic logic op_is_rem(input div_op_e op);
        return (op == OP_REM) || (op == OP_REMU);
    endfunction

endpackage

// File: rtl/seq_divider_if.sv
// Request/response handshake bundle between the execute stage and the divider.
interface seq_divider_if
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
);
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    div_op_e          in_op;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_result;
    logic             out_dz;
    logic             busy;

    // Requester side (execute stage).
    modport master (
        output in_valid, in_a, in_b, in_op, out_ready,
        input  in_ready, out_valid, out_result, out_dz, busy
    );

    // Divider side.
    modport slave (
        input  in_valid, in_a, in_b, in_op, out_ready,
        output in_ready, out_valid, out_result, out_dz, busy
    );
endinterface

// File: rtl/seq_divider_step.sv
// One restoring-division iteration: shift {rem,quo} left and try to
// subtract the divisor from the shifted remainder.
module div_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);
    logic [WIDTH:0] rem_sh;
    logic [WIDTH:0] trial;
    logic           taken;

    // Trial subtract as an adder with the divisor inverted and carry-in 1.
    // When rem's MSB is set the shifted value is at least 2^WIDTH, which
    // always exceeds the divisor, so the subtract succeeds even though the
    // WIDTH+1 bit sign of trial is then meaningless; the low bits are exact.
    always_comb begin
        rem_sh   = {rem, quo[WIDTH-1]};
        trial    = rem_sh + {1'b1, ~divisor} + {{WIDTH{1'b0}}, 1'b1};
        taken    = rem[WIDTH-1] | ~trial[WIDTH];
        rem_next = taken ? trial[WIDTH-1:0] : rem_sh[WIDTH-1:0];
        quo_next = {quo[WIDTH-2:0], taken};
    end
endmodule

// File: rtl/seq_divider.sv
// Multi-cycle radix-2 restoring divider for RV32M DIV/DIVU/REM/REMU.
// One conditional subtract per cycle on magnitudes, then a sign-fix cycle.
// Divide-by-zero and signed overflow bypass the loop straight to DONE.
module seq_divider
    import seq_divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = 6
) (
    input logic         clk,
    input logic         rst,
    seq_divider_if.slave bus
);
    div_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [WIDTH-1:0] rem_q, quo_q, div_q;
    logic [WIDTH-1:0] rem_next, quo_next;
    logic             sel_rem_q;
    logic             neg_quo_q, neg_rem_q;
    logic [WIDTH-1:0] result_q;
    logic             dz_q;

    logic             accept;
    logic             sgn, a_neg, b_neg;
    logic [WIDTH-1:0] a_abs, b_abs;
    logic             is_dz, is_ovf;
    logic             last_iter;
    logic [WIDTH-1:0] quo_fix, rem_fix;

    div_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (div_q),
        .rem_next (rem_next),
        .quo_next (quo_next)
    );

    // Request decode: magnitudes, sign flags and the two bypass cases.
    always_comb begin
        accept    = bus.in_valid && (state_q == S_IDLE);
        sgn       = op_is_signed(bus.in_op);
        a_neg     = sgn & bus.in_a[WIDTH-1];
        b_neg     = sgn & bus.in_b[WIDTH-1];
        a_abs     = a_neg ? (~bus.in_a + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.in_a;
        b_abs     = b_neg ? (~bus.in_b + {{(WIDTH-1){1'b0}}, 1'b1}) : bus.in_b;
        is_dz     = (bus.in_b == '0);
        is_ovf    = sgn && (bus.in_a == {1'b1, {(WIDTH-1){1'b0}}})
                        && (bus.in_b == '1);
        last_iter = (cnt_q == CNT_W'(WIDTH - 1));
        quo_fix   = neg_quo_q ? (~quo_q + {{(WIDTH-1){1'b0}}, 1'b1}) : quo_q;
        rem_fix   = neg_rem_q ? (~rem_q + {{(WIDTH-1){1'b0}}, 1'b1}) : rem_q;
    end

    // State register.
    always_ff @(posedge clk) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE: if (accept) state_d = (is_dz || is_ovf) ? S_DONE : S_CALC;
            S_CALC: if (last_iter) state_d = S_FIX;
            S_FIX:  state_d = S_DONE;
            S_DONE: if (bus.out_ready) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Handshake outputs decode straight from the state register.
    always_comb begin
        bus.in_ready   = (state_q == S_IDLE);
        bus.out_valid  = (state_q == S_DONE);
        bus.busy       = (state_q != S_IDLE);
        bus.out_result = result_q;
        bus.out_dz     = dz_q;
    end

    // Datapath: capture on accept, iterate in CALC, sign-fix in FIX.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q     <= '0;
            rem_q     <= '0;
            quo_q     <= '0;
            div_q     <= '0;
            sel_rem_q <= 1'b0;
            neg_quo_q <= 1'b0;
            neg_rem_q <= 1'b0;
            result_q  <= '0;
            dz_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    sel_rem_q <= op_is_rem(bus.in_op);
                    neg_quo_q <= a_neg ^ b_neg;
                    neg_rem_q <= a_neg;
                    rem_q     <= '0;
                    quo_q     <= a_abs;
                    div_q     <= b_abs;
                    cnt_q     <= '0;
                    dz_q      <= is_dz;
                    if (is_dz)
                        result_q <= op_is_rem(bus.in_op) ? bus.in_a : '1;
                    else if (is_ovf)
                        result_q <= op_is_rem(bus.in_op) ? '0 : bus.in_a;
                end
                S_CALC: begin
                    rem_q <= rem_next;
                    quo_q <= quo_next;
                    cnt_q <= cnt_q + CNT_W'(1);
                end
                S_FIX: result_q <= sel_rem_q ? rem_fix : quo_fix;
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_seq_divider.sv
// Bench for seq_divider: directed table, handshake corner sequences and
// randomized operations checked against an arithmetic reference model.
module tb_seq_divider;
    import seq_divider_pkg::*;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    seq_divider_if #(.WIDTH(32)) bus ();
    seq_divider #(.WIDTH(32), .CNT_W(6)) dut (.clk(clk), .rst(rst), .bus(bus));

    int n_tests = 0;
    int n_fail  = 0;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  op;
        logic [31:0] res;
        logic        dz;
        int          lat;   // edges from accept edge until out_valid seen
    } vec_t;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Reference: RV32M semantics straight from the arithmetic definition.
    function automatic logic [32:0] model(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        int sa, sb;
        logic [31:0] r;
        logic ovf;
        sa  = a;
        sb  = b;
        ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
        if (b == 0) return {1'b1, (op[1] ? a : 32'hFFFF_FFFF)};
        case (op)
            2'd0: r = ovf ? a : 32'(sa / sb);
            2'd1: r = a / b;
            2'd2: r = ovf ? 32'd0 : 32'(sa % sb);
            default: r = a % b;
        endcase
        return {1'b0, r};
    endfunction

    function automatic int model_lat(input logic [31:0] a, input logic [31:0] b, input logic [1:0] op);
        if (b == 0) return 0;
        if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 0;
        return 33;
    endfunction

    // Issue one request, wait for the result, hold it for 'hold' cycles
    // with out_ready low, then complete the output handshake.
    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic [1:0] op, input logic [31:0] res, input logic dz,
                          input int lat, input int hold);
        int k;
        k = 0;
        while (!bus.in_ready && k < 50) begin @(posedge clk); #1; k++; end
        check($sformatf("%s in_ready", tag), 32'(bus.in_ready), 32'd1);
        bus.in_valid = 1'b1;
        bus.in_a     = a;
        bus.in_b     = b;
        bus.in_op    = div_op_e'(op);
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        bus.in_a     = $urandom;
        bus.in_b     = $urandom;
        bus.in_op    = div_op_e'($urandom_range(0, 3));
        k = 0;
        while (!bus.out_valid && k < 100) begin @(posedge clk); #1; k++; end
        check($sformatf("%s latency", tag), 32'(k), 32'(lat));
        check($sformatf("%s result", tag), bus.out_result, res);
        check($sformatf("%s dz", tag), 32'(bus.out_dz), 32'(dz));
        for (int h = 0; h < hold; h++) begin
            @(posedge clk); #1;
            check($sformatf("%s hold%0d valid", tag, h), 32'(bus.out_valid), 32'd1);
            check($sformatf("%s hold%0d result", tag, h), bus.out_result, res);
            check($sformatf("%s hold%0d in_ready", tag, h), 32'(bus.in_ready), 32'd0);
        end
        bus.out_ready = 1'b1;
        @(posedge clk); #1;
        bus.out_ready = 1'b0;
        check($sformatf("%s post valid", tag), 32'(bus.out_valid), 32'd0);
        check($sformatf("%s post in_ready", tag), 32'(bus.in_ready), 32'd1);
    endtask

    vec_t vt[18];

    initial begin
        vt[0]  = '{32'd100,        32'd7,          2'd1, 32'd14,         1'b0, 33};
        vt[1]  = '{32'd100,        32'd7,          2'd3, 32'd2,          1'b0, 33};
        vt[2]  = '{32'hFFFF_FF9C,  32'd7,          2'd0, 32'hFFFF_FFF2,  1'b0, 33};
        vt[3]  = '{32'hFFFF_FF9C,  32'd7,          2'd2, 32'hFFFF_FFFE,  1'b0, 33};
        vt[4]  = '{32'h1234_5678,  32'd0,          2'd1, 32'hFFFF_FFFF,  1'b1, 0};
        vt[5]  = '{32'h1234_5678,  32'd0,          2'd2, 32'h1234_5678,  1'b1, 0};
        vt[6]  = '{32'h8000_0000,  32'hFFFF_FFFF,  2'd0, 32'h8000_0000,  1'b0, 0};
        vt[7]  = '{32'h8000_0000,  32'hFFFF_FFFF,  2'd2, 32'd0,          1'b0, 0};
        vt[8]  = '{32'hFFFF_FFFF,  32'd1,          2'd1, 32'hFFFF_FFFF,  1'b0, 33};
        vt[9]  = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  2'd1, 32'd1,          1'b0, 33};
        vt[10] = '{32'hFFFF_FFFF,  32'hFFFF_FFFE,  2'd3, 32'd1,          1'b0, 33};
        vt[11] = '{32'd7,          32'hFFFF_FFFE,  2'd0, 32'hFFFF_FFFD,  1'b0, 33};
        vt[12] = '{32'd7,          32'hFFFF_FFFE,  2'd2, 32'd1,          1'b0, 33};
        vt[13] = '{32'h8000_0000,  32'hFFFF_FFFF,  2'd1, 32'd0,          1'b0, 33};
        vt[14] = '{32'h8000_0000,  32'hFFFF_FFFF,  2'd3, 32'h8000_0000,  1'b0, 33};
        vt[15] = '{32'h8000_0000,  32'd2,          2'd0, 32'hC000_0000,  1'b0, 33};
        vt[16] = '{32'd5,          32'd0,          2'd0, 32'hFFFF_FFFF,  1'b1, 0};
        vt[17] = '{32'hDEAD_BEEF,  32'd0,          2'd3, 32'hDEAD_BEEF,  1'b1, 0};

        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.in_a      = '0;
        bus.in_b      = '0;
        bus.in_op     = OP_DIV;
        bus.out_ready = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        check("reset in_ready",  32'(bus.in_ready),  32'd1);
        check("reset out_valid", 32'(bus.out_valid), 32'd0);
        check("reset result",    bus.out_result,     32'd0);
        check("reset dz",        32'(bus.out_dz),    32'd0);
        check("reset busy",      32'(bus.busy),      32'd0);
        rst = 1'b0;

        // out_ready while idle must not disturb anything.
        bus.out_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        check("idle out_ready valid", 32'(bus.out_valid), 32'd0);
        check("idle out_ready ready", 32'(bus.in_ready),  32'd1);

        for (int i = 0; i < 18; i++)
            run_op($sformatf("vec%0d", i), vt[i].a, vt[i].b, vt[i].op,
                   vt[i].res, vt[i].dz, vt[i].lat, 0);

        // Backpressure: result held for 10 cycles, then a fresh request.
        run_op("bp", 32'd50, 32'd5, 2'd1, 32'd10, 1'b0, 33, 10);
        run_op("bp next", 32'd100, 32'd7, 2'd1, 32'd14, 1'b0, 33, 0);

        // Reset mid-CALC discards the in-flight operation.
        bus.in_valid = 1'b1;
        bus.in_a     = 32'd1000;
        bus.in_b     = 32'd3;
        bus.in_op    = OP_DIVU;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        check("midcalc busy", 32'(bus.busy), 32'd1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("midrst in_ready",  32'(bus.in_ready),  32'd1);
        check("midrst out_valid", 32'(bus.out_valid), 32'd0);
        check("midrst busy",      32'(bus.busy),      32'd0);
        check("midrst result",    bus.out_result,     32'd0);
        run_op("after rst", 32'd9, 32'd3, 2'd1, 32'd3, 1'b0, 33, 0);

        // Randomized operations against the reference model.
        for (int i = 0; i < 60; i++) begin
            logic [31:0] a, b;
            logic [1:0]  op;
            logic [32:0] m;
            int          sel;
            op  = 2'($urandom_range(0, 3));
            sel = $urandom_range(0, 9);
            a   = $urandom;
            b   = $urandom >> $urandom_range(0, 31);
            if (sel == 0) b = 32'd0;
            else if (sel == 1) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            else if (sel == 2) begin a = $urandom_range(0, 300); b = $urandom_range(1, 20); end
            else if (sel == 3) b = -($urandom_range(1, 50));
            m = model(a, b, op);
            run_op($sformatf("rnd%0d op%0d %h/%h", i, op, a, b), a, b, op,
                   m[31:0], m[32], model_lat(a, b, op), $urandom_range(0, 2));
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
